// File: rtl/perf_event_sched.sv
// Round-robin scheduler for three read-only perf counters sharing one incrementer, plus a
// four-phase req/ack read port. Define PERF_CLEAR_ON_READ_EN for destructive reads.

module perf_event_slot #(
  parameter int CNT_W  = 20,
  parameter int PEND_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_i,
  input  logic             gnt_i,
  input  logic             clr_cnt_i,
  input  logic             clr_drop_i,
  output logic             pend_nz_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             drop_o
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;

  always_comb begin
    pend_d = pend_q;
    // a drop on the clearing edge must win so the loss is not hidden
    drop_d = drop_q & ~clr_drop_i;
    case ({ev_i, gnt_i})
      2'b10: begin
        if (pend_q == PEND_MAX) drop_d = 1'b1;
        else                    pend_d = pend_q + PEND_ONE;
      end
      2'b01:   pend_d = pend_q - PEND_ONE;
      default: ;
    endcase
    cnt_d = clr_cnt_i ? '0 : cnt_q;
    if (gnt_i) cnt_d = cnt_d + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  assign pend_nz_o = |pend_q;
  assign cnt_o     = cnt_q;
  assign drop_o    = drop_q;
endmodule

module perf_event_sched #(
  parameter int CNT_W  = 20,
  parameter int PEND_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev_instr_i,
  input  logic             ev_mem_acc_i,
  input  logic             ev_mem_corr_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_sel_i,
  output logic             rd_ack_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [2:0]       ev_drop_o,
  output logic             busy_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAPT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [2:0]            ev, gnt, clr_cnt, pend_nz, drop;
  logic [2:0][CNT_W-1:0] cnt;
  logic                  clr_drop, capt, gnt_vld;
  logic [1:0]            gidx, rr_q, rr_d;
  logic [2:0]            cand;
  logic [1:0]            state_q, state_d, sel_q, sel_d;
  logic                  ack_q, ack_d;
  logic [CNT_W-1:0]      data_q, data_d;

  assign ev = {ev_mem_corr_i, ev_mem_acc_i, ev_instr_i};

  for (genvar i = 0; i < 3; i++) begin : g_slot
    perf_event_slot #(.CNT_W(CNT_W), .PEND_W(PEND_W)) u_slot (
      .clk        (clk),
      .reset      (reset),
      .ev_i       (ev[i]),
      .gnt_i      (gnt[i]),
      .clr_cnt_i  (clr_cnt[i]),
      .clr_drop_i (clr_drop),
      .pend_nz_o  (pend_nz[i]),
      .cnt_o      (cnt[i]),
      .drop_o     (drop[i])
    );
  end

  // search from the RR pointer upward, modulo 3
  always_comb begin
    gnt_vld = 1'b0;
    gidx    = rr_q;
    cand    = '0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!gnt_vld && pend_nz[cand[1:0]]) begin
        gnt_vld = 1'b1;
        gidx    = cand[1:0];
      end
    end
    gnt  = gnt_vld ? (3'b001 << gidx) : 3'b000;
    rr_d = gnt_vld ? ((gidx == 2'd2) ? 2'd0 : gidx + 2'd1) : rr_q;
  end

  assign capt = (state_q == S_CAPT);

`ifdef PERF_CLEAR_ON_READ_EN
  assign clr_cnt  = (capt && sel_q != 2'd3) ? (3'b001 << sel_q) : 3'b000;
  assign clr_drop = capt && (sel_q == 2'd3);
`else
  assign clr_cnt  = 3'b000;
  assign clr_drop = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ack_d   = ack_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (rd_req_i) begin
        sel_d   = rd_sel_i;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        // sampled before any increment committing on this same edge
        data_d  = (sel_q == 2'd3) ? {{(CNT_W-3){1'b0}}, drop} : cnt[sel_q];
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: if (!rd_req_i) begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q    <= 2'd0;
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign rd_ack_o  = ack_q;
  assign rd_data_o = data_q;
  assign ev_drop_o = drop;
  assign busy_o    = |pend_nz;
endmodule

// File: tb/tb_perf_event_sched.sv
// Scoreboard bench for perf_event_sched: grants and read data are queued when stimulus
// is driven and popped when the DUT presents them. A 4-bit instance covers counter wrap.

module tb_perf_event_sched;
  localparam int CNT_W  = 20;
  localparam int PEND_W = 3;
`ifdef PERF_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             ev_instr, ev_mem_acc, ev_mem_corr, rd_req;
  logic [1:0]       rd_sel;
  logic             rd_ack, busy;
  logic [CNT_W-1:0] rd_data;
  logic [2:0]       ev_drop;

  logic             ev_corr_w, rd_req_w, rd_ack_w, busy_w;
  logic [1:0]       rd_sel_w;
  logic [3:0]       rd_data_w;
  logic [2:0]       ev_drop_w;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int gnt_q[$];

  always #5 clk = ~clk;

  perf_event_sched #(.CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
    .clk(clk), .reset(reset), .ev_instr_i(ev_instr), .ev_mem_acc_i(ev_mem_acc),
    .ev_mem_corr_i(ev_mem_corr), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_ack_o(rd_ack), .rd_data_o(rd_data), .ev_drop_o(ev_drop), .busy_o(busy)
  );

  perf_event_sched #(.CNT_W(4), .PEND_W(PEND_W)) dut_w (
    .clk(clk), .reset(reset), .ev_instr_i(1'b0), .ev_mem_acc_i(1'b0),
    .ev_mem_corr_i(ev_corr_w), .rd_req_i(rd_req_w), .rd_sel_i(rd_sel_w),
    .rd_ack_o(rd_ack_w), .rd_data_o(rd_data_w), .ev_drop_o(ev_drop_w), .busy_o(busy_w)
  );

  task automatic set_ev(input logic v);
    ev_instr = v; ev_mem_acc = v; ev_mem_corr = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_ev(1'b0); rd_req = 1'b0; rd_sel = 2'd0;
    ev_corr_w = 1'b0; rd_req_w = 1'b0; rd_sel_w = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || busy_w !== 1'b0) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0 || busy_w !== 1'b0) begin
      errors++; $display("FAIL %s: busy=%b busy_w=%b still high, required 0", nm, busy, busy_w);
    end
  endtask

  task automatic do_read(input logic [1:0] sel, input string nm);
    int n;
    int e;
    @(posedge clk); #1;
    rd_sel = sel; rd_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (rd_ack !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    e = exp_q.pop_front();
    checks++;
    if (rd_ack !== 1'b1) begin
      errors++; $display("FAIL %s: rd_ack never rose, required 1", nm);
    end else if (rd_data !== CNT_W'(e)) begin
      errors++; $display("FAIL %s: rd_data=%0d, required %0d", nm, rd_data, e);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (rd_ack !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (rd_ack !== 1'b0) begin errors++; $display("FAIL %s_release: rd_ack=%b, required 0", nm, rd_ack); end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (rd_ack !== 1'b0)   begin errors++; $display("FAIL reset_ack: %b, required 0", rd_ack); end
    if (rd_data !== '0)    begin errors++; $display("FAIL reset_data: %0d, required 0", rd_data); end
    if (ev_drop !== 3'b0)  begin errors++; $display("FAIL reset_drop: %b, required 000", ev_drop); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: %b, required 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    @(posedge clk); #1 ev_instr = 1'b1;
    @(posedge clk); #1 ev_instr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hi: %b, required 1", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_lo: %b, required 0", busy); end
    exp_q.push_back(1); do_read(2'd0, "single_instr");
    exp_q.push_back(0); do_read(2'd1, "single_mem_acc");
    exp_q.push_back(0); do_read(2'd2, "single_mem_corr");
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    @(posedge clk); #1 set_ev(1'b1);
    for (int k = 0; k < 12; k++) gnt_q.push_back(k % 3);
    @(posedge clk);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      e = gnt_q.pop_front();
      checks++;
      if (dut.gnt_vld !== 1'b1 || dut.gidx !== e[1:0]) begin
        errors++; $display("FAIL rr_grant%0d: vld=%b idx=%0d, required vld=1 idx=%0d", n, dut.gnt_vld, dut.gidx, e);
      end
      @(posedge clk);
      if (n == 2) begin #1 set_ev(1'b0); end
    end
    wait_idle("rr_drain");
    checks++;
    if (ev_drop !== 3'b000) begin errors++; $display("FAIL rr_drop: %b, required 000", ev_drop); end
    exp_q.push_back(4); do_read(2'd0, "rr_instr");
    exp_q.push_back(4); do_read(2'd1, "rr_mem_acc");
    exp_q.push_back(4); do_read(2'd2, "rr_mem_corr");
  endtask

  task automatic test_saturation();
    do_reset();
    @(posedge clk); #1 set_ev(1'b1);
    repeat (20) @(posedge clk);
    #1 set_ev(1'b0);
    wait_idle("sat_drain");
    checks++;
    if (ev_drop !== 3'b111) begin errors++; $display("FAIL sat_drop: %b, required 111", ev_drop); end
    exp_q.push_back(14); do_read(2'd0, "sat_instr");
    exp_q.push_back(13); do_read(2'd1, "sat_mem_acc");
    exp_q.push_back(13); do_read(2'd2, "sat_mem_corr");
    exp_q.push_back(7);  do_read(2'd3, "sat_status");
    exp_q.push_back(CLR ? 0 : 7); do_read(2'd3, "sat_status2");
    checks++;
    if (ev_drop !== (CLR ? 3'b000 : 3'b111)) begin
      errors++; $display("FAIL sat_drop_after_read: %b, required %b", ev_drop, CLR ? 3'b000 : 3'b111);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    @(posedge clk); #1 ev_corr_w = 1'b1;
    repeat (15) @(posedge clk);
    #1 ev_corr_w = 1'b0;
    wait_idle("wrap_fill");
    @(posedge clk); #1 ev_corr_w = 1'b1;
    @(posedge clk); #1 ev_corr_w = 1'b0;
    wait_idle("wrap_last");
    exp_q.push_back(0);
    @(posedge clk); #1 rd_sel_w = 2'd2; rd_req_w = 1'b1;
    n = 0;
    @(negedge clk);
    while (rd_ack_w !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = exp_q.pop_front();
    checks += 2;
    if (rd_ack_w !== 1'b1 || rd_data_w !== 4'(n)) begin
      errors++; $display("FAIL wrap_data: ack=%b data=%0d, required ack=1 data=%0d", rd_ack_w, rd_data_w, n);
    end
    if (ev_drop_w !== 3'b000) begin errors++; $display("FAIL wrap_flag: %b, required 000", ev_drop_w); end
    @(posedge clk); #1 rd_req_w = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_read_handshake();
    int e;
    do_reset();
    @(posedge clk); #1 ev_instr = 1'b1;
    repeat (5) @(posedge clk);
    #1 ev_instr = 1'b0;
    wait_idle("hs_fill");
    @(posedge clk); #1 rd_sel = 2'd0; rd_req = 1'b1;
    exp_q.push_back(5);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b0) begin errors++; $display("FAIL hs_capt_ack: %b, required 0", rd_ack); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rd_ack !== 1'b1 || rd_data !== CNT_W'(e)) begin
      errors++; $display("FAIL hs_ack_rise: ack=%b data=%0d, required ack=1 data=%0d", rd_ack, rd_data, e);
    end
    rd_sel = 2'd2;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (rd_ack !== 1'b1 || rd_data !== CNT_W'(e)) begin
        errors++; $display("FAIL hs_hold%0d: ack=%b data=%0d, required ack=1 data=%0d", n, rd_ack, rd_data, e);
      end
    end
    @(posedge clk); #1 rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b1) begin errors++; $display("FAIL hs_ack_late: %b, required 1", rd_ack); end
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b0 || rd_data !== CNT_W'(e)) begin
      errors++; $display("FAIL hs_ack_fall: ack=%b data=%0d, required ack=0 data=%0d", rd_ack, rd_data, e);
    end
    exp_q.push_back(CLR ? 0 : 5); do_read(2'd0, "hs_second_read");
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    @(posedge clk); #1 set_ev(1'b1);
    repeat (12) @(posedge clk);
    #1 rd_sel = 2'd0; rd_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (rd_ack !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (rd_ack !== 1'b1 || busy !== 1'b1 || ev_drop !== 3'b111) begin
      errors++; $display("FAIL mid_pre: ack=%b busy=%b drop=%b, required 1 1 111", rd_ack, busy, ev_drop);
    end
    @(posedge clk); #2;
    reset = 1'b1; set_ev(1'b0);
    #1;
    checks += 4;
    if (rd_ack !== 1'b0)  begin errors++; $display("FAIL mid_ack: %b, required 0", rd_ack); end
    if (rd_data !== '0)   begin errors++; $display("FAIL mid_data: %0d, required 0", rd_data); end
    if (ev_drop !== 3'b0) begin errors++; $display("FAIL mid_drop: %b, required 000", ev_drop); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL mid_busy: %b, required 0", busy); end
    rd_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    exp_q.push_back(0); do_read(2'd0, "mid_instr");
    exp_q.push_back(0); do_read(2'd1, "mid_mem_acc");
    exp_q.push_back(0); do_read(2'd2, "mid_mem_corr");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_saturation();
    test_wrap();
    test_read_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/perf_event_sched.md
# perf_event_sched

Scheduler and read controller for the processor's read-only performance counters (instruction count, memory access, memory correction). It buffers event pulses from the pipeline and memory unit, and arbitrates a single shared CNT_W-bit incrementer between the three sources round-robin. It also serves counter reads to the CPU over a four-phase req/ack handshake. It sits between the event producers and the CSR read path.

## Interface
- CNT_W, 20, width of each event counter and of rd_data
- PEND_W, 3, width of each per-source pending-event buffer
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- ev_instr  in  1  instruction-retired event, one count per cycle high
- ev_mem_acc  in  1  memory-access event
- ev_mem_corr  in  1  memory-correction event
- rd_req  in  1  read request, level, four-phase
- rd_sel  in  2  0=instr, 1=mem_acc, 2=mem_corr, 3=drop-flag status
- rd_ack  out  1  read acknowledge
- rd_data  out  CNT_W  read data, valid while rd_ack high
- ev_drop  out  3  sticky per-source "event lost" flags, bit0=instr, bit1=mem_acc, bit2=mem_corr
- busy  out  1  high while any pending buffer is non-zero, combinational

## Operation
- Reset values: all counters 0, pending 0, ev_drop 0, RR pointer 0, rd_ack 0, rd_data 0, FSM IDLE. busy is 0 as a consequence.
- Pending buffer per source, PEND_W bits, saturating at 2^PEND_W-1:
  - Event only: +1.
  - Grant only: -1.
  - Event and grant in the same cycle: unchanged.
  - Event while saturated with no grant: value held, ev_drop[i] set. The flag stays set until reset or until it is cleared by a read (see Configuration).
- Arbiter: one grant per cycle, among sources with pending > 0.
  - Search order starts at the RR pointer, increasing index mod 3.
  - After a grant to source g, the pointer becomes (g+1) mod 3. With no grant, the pointer holds.
- Counter: on a grant, the selected counter += 1 mod 2^CNT_W. All-ones wraps to 0 with no flag.
- Read FSM states:
  - IDLE: if rd_req, latch rd_sel and go to CAPT.
  - CAPT: load rd_data from the latched source and go to ACK. Source 3 returns ev_drop zero-extended.
  - ACK: rd_ack=1. Stay while rd_req is high; on rd_req low go to IDLE with rd_ack=0.
- rd_data holds its value after rd_ack falls, until the next CAPT.
- The CAPT sample is the counter value before any increment committed on that same edge.
- Event inputs are accepted in every FSM state. Reads never stall counting.

## Timing
- Event high before edge k: pending updates at k. With no contention, the counter increments at edge k+1 (latency 2 edges).
- Worst case with all three sources pending: a given source waits at most 3 grant cycles.
- Sustained event rate: each source can sustain 1 event per 3 cycles with all three active. Bursts are absorbed up to 2^PEND_W-1.
- Read: rd_req sampled high at edge k → CAPT. At edge k+1, rd_data is loaded and rd_ack rises. rd_req sampled low at edge m → rd_ack low after edge m. The minimum new request is accepted at edge m+1.
- rd_sel is sampled only in IDLE. Changes during CAPT or ACK are ignored.
- Reset asserted mid-read or mid-burst: rd_ack drops and all state clears immediately (asynchronous). Pending events are discarded.

## Configuration
- PERF_CLEAR_ON_READ_EN defined:
  - The CAPT cycle clears the selected counter to 0.
  - If a grant to the same counter commits on that edge, the counter becomes 1; the increment is not lost.
  - rd_sel=3 in CAPT clears ev_drop. A drop occurring on that same edge re-sets its flag.
- PERF_CLEAR_ON_READ_EN undefined: reads are non-destructive. ev_drop clears only on reset.

## Test plan
- Reset, then ev_instr pulsed for 1 cycle → instr counter reads 1; other two counters read 0; busy low 2 cycles after the pulse.
- All three events high for 4 consecutive cycles starting after reset:
  - Grants are strictly 0,1,2,0,1,2,….
  - Each counter reaches 4 by cycle 12.
  - ev_drop stays 0 with PEND_W=3.
- ev_mem_acc held high for 20 cycles while the other events are also high → mem_acc pending saturates at 7, ev_drop[1]=1, and the counter ends below 20.
- Counter preloaded via 2^20-1 mem_corr events, plus one more event → reads 0, no flag.
- Read handshake:
  - rd_sel=0 with counter=5: rd_ack rises one edge after CAPT with rd_data=5, and holds until rd_req drops.
  - Under PERF_CLEAR_ON_READ_EN, a second read returns 0, or 1 if a grant to that counter coincided with CAPT.
- Reset asserted while rd_ack=1 and pending non-zero → rd_ack, rd_data, counters, pending and ev_drop all 0 immediately.
